// File: rtl/tx_burst_gate_if.sv
// Handshake bundle between a transducer channel's PWM source/controller and tx_burst_gate.
// The master modport is the controlling side; the slave modport is the gate itself.
interface tx_burst_gate_if #(
  parameter int unsigned MAX_BURST     = 255,
  parameter int unsigned LISTEN_CLOCKS = 2_000_000
);
  localparam int unsigned LenW = $clog2(MAX_BURST + 1);
  localparam int unsigned LcW  = $clog2(LISTEN_CLOCKS);

  logic            pwm_in;
  logic            trigger_in;
  logic            abort_in;
  logic [LenW-1:0] burst_len_in;
  logic            tx_out;
  logic            busy_out;
  logic            listen_out;
  logic [LcW-1:0]  listen_count_out;
  logic            done_out;
  logic            fault_out;

  modport master (
    output pwm_in,
    output trigger_in,
    output abort_in,
    output burst_len_in,
    input  tx_out,
    input  busy_out,
    input  listen_out,
    input  listen_count_out,
    input  done_out,
    input  fault_out
  );

  modport slave (
    input  pwm_in,
    input  trigger_in,
    input  abort_in,
    input  burst_len_in,
    output tx_out,
    output busy_out,
    output listen_out,
    output listen_count_out,
    output done_out,
    output fault_out
  );
endinterface

// File: rtl/tx_burst_gate.sv
// Gates a free-running PWM square wave into a ping of whole periods, then opens a timed
// listen window for echo capture. All outputs come straight from flops.
module tx_burst_gate #(
  parameter int unsigned PWM_PERIOD    = 2500,
  parameter int unsigned MAX_BURST     = 255,
  parameter int unsigned LISTEN_CLOCKS = 2_000_000
) (
  input logic           clk_in,
  input logic           rst_in,
  tx_burst_gate_if.slave bus
);

  localparam int unsigned LenW = $clog2(MAX_BURST + 1);
  localparam int unsigned LcW  = $clog2(LISTEN_CLOCKS);
  localparam int unsigned ArmW = $clog2(2 * PWM_PERIOD);

  localparam logic [ArmW-1:0] ArmLast    = ArmW'(2 * PWM_PERIOD - 1);
  localparam logic [LcW-1:0]  ListenLast = LcW'(LISTEN_CLOCKS - 1);

  typedef enum logic [1:0] {StIdle, StArm, StBurst, StListen} state_e;

  state_e          state_q;
  logic            pwm_q;
  logic [LenW-1:0] len_q;
  logic [ArmW-1:0] arm_cnt_q;
  logic [LenW-1:0] edge_cnt_q;
  logic [LcW-1:0]  listen_cnt_q;
  logic            tx_q;
  logic            busy_q;
  logic            listen_q;
  logic            done_q;
  logic            fault_q;

  logic            pwm_edge;
  logic [LenW-1:0] len_clamped;

  assign pwm_edge = bus.pwm_in & ~pwm_q;

  // A zero request still emits one period; oversize requests saturate at MAX_BURST.
  always_comb begin
    len_clamped = bus.burst_len_in;
    if (bus.burst_len_in == '0) begin
      len_clamped = LenW'(1);
    end else if (int'(bus.burst_len_in) > int'(MAX_BURST)) begin
      len_clamped = LenW'(MAX_BURST);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      pwm_q        <= 1'b0;
      len_q        <= '0;
      arm_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      listen_cnt_q <= '0;
      tx_q         <= 1'b0;
      busy_q       <= 1'b0;
      listen_q     <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pwm_q   <= bus.pwm_in;
      done_q  <= 1'b0;
      fault_q <= 1'b0;

      // Abort outranks every other event in the active states.
      if (bus.abort_in && (state_q != StIdle)) begin
        state_q      <= StIdle;
        tx_q         <= 1'b0;
        busy_q       <= 1'b0;
        listen_q     <= 1'b0;
        arm_cnt_q    <= '0;
        edge_cnt_q   <= '0;
        listen_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.trigger_in && !bus.abort_in) begin
              state_q   <= StArm;
              busy_q    <= 1'b1;
              len_q     <= len_clamped;
              arm_cnt_q <= '0;
            end
          end

          StArm: begin
            if (pwm_edge) begin
              state_q    <= StBurst;
              edge_cnt_q <= LenW'(1);
              tx_q       <= 1'b1;
              arm_cnt_q  <= '0;
            end else if (arm_cnt_q == ArmLast) begin
              // No PWM edge within two periods: the generator is stalled.
              state_q   <= StIdle;
              busy_q    <= 1'b0;
              fault_q   <= 1'b1;
              arm_cnt_q <= '0;
            end else begin
              arm_cnt_q <= arm_cnt_q + ArmW'(1);
            end
          end

          StBurst: begin
            tx_q <= bus.pwm_in;
            if (pwm_edge) begin
              if (edge_cnt_q == len_q) begin
                // Edge that would start period len_q+1 closes the ping instead.
                state_q      <= StListen;
                tx_q         <= 1'b0;
                listen_q     <= 1'b1;
                listen_cnt_q <= '0;
                edge_cnt_q   <= '0;
              end else begin
                edge_cnt_q <= edge_cnt_q + LenW'(1);
              end
            end
          end

          StListen: begin
            if (listen_cnt_q == ListenLast) begin
              state_q      <= StIdle;
              busy_q       <= 1'b0;
              listen_q     <= 1'b0;
              done_q       <= 1'b1;
              listen_cnt_q <= '0;
            end else begin
              listen_cnt_q <= listen_cnt_q + LcW'(1);
            end
          end

          default: begin
            state_q  <= StIdle;
            tx_q     <= 1'b0;
            busy_q   <= 1'b0;
            listen_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tx_out           = tx_q;
  assign bus.busy_out         = busy_q;
  assign bus.listen_out       = listen_q;
  assign bus.listen_count_out = listen_cnt_q;
  assign bus.done_out         = done_q;
  assign bus.fault_out        = fault_q;

endmodule

// File: tb/tb_tx_burst_gate.sv
// Randomized bench for tx_burst_gate: each scenario records every post-edge output vector
// and compares it against an event-level ping model derived from the PWM waveform.
module tb_tx_burst_gate;

  localparam int unsigned PP    = 10;
  localparam int unsigned MB    = 5;
  localparam int unsigned LC    = 50;
  localparam int          WMAX  = 600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_burst_gate_if #(.MAX_BURST(MB), .LISTEN_CLOCKS(LC)) bus ();

  tx_burst_gate #(
    .PWM_PERIOD   (PP),
    .MAX_BURST    (MB),
    .LISTEN_CLOCKS(LC)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit pwm_on;
  int ph;

  // Vector layout: {tx, busy, listen, done, fault, listen_count[5:0]}
  logic [10:0] ex [0:WMAX-1];
  logic [10:0] ob [0:WMAX-1];

  function automatic bit pv(input int k);
    return pwm_on && (((k + ph) % 10) < 5);
  endfunction

  function automatic bit rise(input int k);
    return pv(k) && !pv(k - 1);
  endfunction

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > int'(MB)) return int'(MB);
    return l;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < WMAX; i++) ex[i] = '0;
  endtask

  // One ping accepted at step t: ARM until the first rising PWM edge a (or time out after
  // 20 clocks), tx copies pwm until the L-th further edge b, then LC cycles of listening.
  task automatic model_ping(input int t, input int len_req, input int abort_at,
                            output int a_o, output int b_o, output int end_o);
    int L, cnt, nat_end, e;
    bit aborted;
    logic tx_b, busy_b, lis_b, dn_b, fl_b;
    logic [5:0] c;
    L   = clamp_len(len_req);
    a_o = -1;
    b_o = -1;
    for (int n = t + 1; n <= t + 20; n++) begin
      if (rise(n)) begin
        a_o = n;
        break;
      end
    end
    if (a_o < 0) begin
      nat_end = t + 20;
    end else begin
      cnt = 0;
      b_o = a_o;
      for (int n = a_o + 1; n < a_o + 2000 && cnt < L; n++) begin
        if (rise(n)) begin
          cnt++;
          b_o = n;
        end
      end
      nat_end = b_o + int'(LC);
    end
    aborted = (abort_at > t) && (abort_at <= nat_end);
    e = aborted ? abort_at : nat_end;
    for (int n = t; n <= e; n++) begin
      busy_b = (n < e);
      tx_b   = (a_o >= 0) && (n >= a_o) && (n < b_o) && (n < e) && pv(n);
      lis_b  = (a_o >= 0) && (n >= b_o) && (n < e);
      c      = lis_b ? 6'(n - b_o) : 6'd0;
      dn_b   = (n == e) && !aborted && (a_o >= 0);
      fl_b   = (n == e) && !aborted && (a_o < 0);
      ex[n]  = {tx_b, busy_b, lis_b, dn_b, fl_b, c};
    end
    end_o = e;
  endtask

  task automatic step(input int k, input bit trig, input bit ab);
    @(negedge clk);
    bus.pwm_in     = pv(k);
    bus.trigger_in = trig;
    bus.abort_in   = ab;
    @(posedge clk);
    #1;
    ob[k] = {bus.tx_out, bus.busy_out, bus.listen_out, bus.done_out, bus.fault_out,
             bus.listen_count_out};
  endtask

  task automatic test_reset();
    logic [10:0] got;
    rst = 1'b1;
    #12;
    got = {bus.tx_out, bus.busy_out, bus.listen_out, bus.done_out, bus.fault_out,
           bus.listen_count_out};
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got, 11'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int t, a, b, e, pulses, lis, dn;
    clear_exp();
    pwm_on = 1;
    ph = $urandom_range(0, 9);
    t  = $urandom_range(2, 11);
    bus.burst_len_in = 3'd3;
    model_ping(t, 3, -1, a, b, e);
    for (int k = 0; k < e + 5; k++) step(k, k == t, 1'b0);
    pulses = 0; lis = 0; dn = 0;
    for (int k = 0; k < e + 5; k++) begin
      checks++;
      if (ob[k] !== ex[k]) begin
        errors++;
        $display("FAIL basic cycle %0d: got %h expected %h", k, ob[k], ex[k]);
      end
      if (k > 0 && ob[k][10] && !ob[k-1][10]) pulses++;
      lis += int'(ob[k][8]);
      dn  += int'(ob[k][7]);
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL basic_pulses: got %0d expected 3", pulses);
    end
    checks++;
    if (lis !== int'(LC)) begin
      errors++;
      $display("FAIL basic_listen_len: got %0d expected %0d", lis, LC);
    end
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d expected 1", dn);
    end
  endtask

  // Covers zero-length, over-range and random lengths; len_sel < 0 picks at random.
  task automatic test_lengths(input int len_sel, input string name);
    int t, a, b, e, pulses, len;
    clear_exp();
    pwm_on = 1;
    ph  = $urandom_range(0, 9);
    t   = $urandom_range(2, 11);
    len = (len_sel < 0) ? int'($urandom_range(0, 7)) : len_sel;
    bus.burst_len_in = 3'(len);
    model_ping(t, len, -1, a, b, e);
    for (int k = 0; k < e + 5; k++) step(k, k == t, 1'b0);
    pulses = 0;
    for (int k = 0; k < e + 5; k++) begin
      checks++;
      if (ob[k] !== ex[k]) begin
        errors++;
        $display("FAIL %s len %0d cycle %0d: got %h expected %h", name, len, k, ob[k], ex[k]);
      end
      if (k > 0 && ob[k][10] && !ob[k-1][10]) pulses++;
    end
    checks++;
    if (pulses !== clamp_len(len)) begin
      errors++;
      $display("FAIL %s_pulses len %0d: got %0d expected %0d", name, len, pulses,
               clamp_len(len));
    end
  endtask

  task automatic test_timeout();
    int t, a, b, e;
    clear_exp();
    pwm_on = 0;
    ph = 0;
    t  = $urandom_range(2, 6);
    bus.burst_len_in = 3'(int'($urandom_range(0, 7)));
    model_ping(t, 3, -1, a, b, e);
    for (int k = 0; k < e + 5; k++) step(k, k == t, 1'b0);
    for (int k = 0; k < e + 5; k++) begin
      checks++;
      if (ob[k] !== ex[k]) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %h expected %h", k, ob[k], ex[k]);
      end
    end
    checks++;
    if (ob[t+20][6] !== 1'b1 || ob[t+19][9] !== 1'b1 || ob[t+20][9] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fault_point: got fault=%b busy=%b expected fault=1 busy=0",
               ob[t+20][6], ob[t+20][9]);
    end
  endtask

  task automatic test_abort();
    int t, a, b, e, m, t2, a2, b2, e2;
    clear_exp();
    pwm_on = 1;
    ph = $urandom_range(0, 9);
    t  = $urandom_range(2, 11);
    bus.burst_len_in = 3'd4;
    model_ping(t, 4, -1, a, b, e);
    m = a + 10 + int'($urandom_range(0, 9));
    clear_exp();
    model_ping(t, 4, m, a, b, e);
    t2 = m + 1;
    model_ping(t2, 4, -1, a2, b2, e2);
    for (int k = 0; k < e2 + 5; k++) step(k, (k == t) || (k == t2), k == m);
    for (int k = 0; k < e2 + 5; k++) begin
      checks++;
      if (ob[k] !== ex[k]) begin
        errors++;
        $display("FAIL abort cycle %0d: got %h expected %h", k, ob[k], ex[k]);
      end
    end
    checks++;
    if (ob[m][10:9] !== 2'b00 || ob[m][7] !== 1'b0) begin
      errors++;
      $display("FAIL abort_point: got tx/busy/done %b%b%b expected 000", ob[m][10], ob[m][9],
               ob[m][7]);
    end
  endtask

  task automatic test_async_reset();
    int t, a, b, e, target;
    logic [10:0] got;
    clear_exp();
    pwm_on = 1;
    ph = $urandom_range(0, 9);
    t  = $urandom_range(2, 11);
    bus.burst_len_in = 3'(int'($urandom_range(1, 3)));
    model_ping(t, int'(bus.burst_len_in), -1, a, b, e);
    target = b + 17;
    for (int k = 0; k <= target; k++) step(k, k == t, 1'b0);
    for (int k = 0; k <= target; k++) begin
      checks++;
      if (ob[k] !== ex[k]) begin
        errors++;
        $display("FAIL async_pre cycle %0d: got %h expected %h", k, ob[k], ex[k]);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    got = {bus.tx_out, bus.busy_out, bus.listen_out, bus.done_out, bus.fault_out,
           bus.listen_count_out};
    checks++;
    if (got !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", got, 11'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t, a, b, e1, t2, a2, b2, e2;
    clear_exp();
    pwm_on = 1;
    ph = $urandom_range(0, 9);
    t  = $urandom_range(2, 11);
    bus.burst_len_in = 3'(int'($urandom_range(1, 3)));
    model_ping(t, int'(bus.burst_len_in), -1, a, b, e1);
    t2 = e1 + 1;
    model_ping(t2, int'(bus.burst_len_in), -1, a2, b2, e2);
    for (int k = 0; k < e2 + 5; k++) step(k, (k >= t) && (k <= t2), 1'b0);
    for (int k = 0; k < e2 + 5; k++) begin
      checks++;
      if (ob[k] !== ex[k]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", k, ob[k], ex[k]);
      end
    end
    checks++;
    if (ob[e1][7] !== 1'b1 || ob[e1][9] !== 1'b0 || ob[t2][9] !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_gap: got done=%b busy=%b next_busy=%b expected 1 0 1",
               ob[e1][7], ob[e1][9], ob[t2][9]);
    end
  endtask

  initial begin
    bus.pwm_in       = 1'b0;
    bus.trigger_in   = 1'b0;
    bus.abort_in     = 1'b0;
    bus.burst_len_in = '0;
    pwm_on = 0;
    ph     = 0;
    test_reset();
    test_basic();
    test_lengths(0, "zero_len");
    test_lengths(int'($urandom_range(MB + 1, 7)), "over_range");
    for (int i = 0; i < 4; i++) test_lengths(-1, "random_len");
    test_timeout();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tx_burst_gate.md
# tx_burst_gate

Gates the free-running 40 kHz square wave from a transducer channel's PWM generator into a finite ultrasonic ping. After the ping it opens a timed listen window for echo capture. The block sits directly downstream of the per-channel PWM generator and drives the transducer driver pin. It also tells the receive path when to listen and for how long.

## Interface

Parameters:
- PWM_PERIOD, 2500: PWM period in clocks (40 kHz at 100 MHz). Sets the arm timeout.
- MAX_BURST, 255: largest accepted burst length, in PWM periods.
- LISTEN_CLOCKS, 2_000_000: listen window length in clocks (20 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset. Asynchronous, active-high.
- pwm_in  input  1  square wave from the PWM generator, synchronous to clk_in.
- trigger_in  input  1  ping request, level-sampled. Accepted only in IDLE.
- abort_in  input  1  cancel any ping in progress.
- burst_len_in  input  $clog2(MAX_BURST+1)  number of PWM periods to emit. Sampled when a trigger is accepted.
- tx_out  output  1  gated transducer drive.
- busy_out  output  1  high in every state except IDLE.
- listen_out  output  1  high while in LISTEN.
- listen_count_out  output  $clog2(LISTEN_CLOCKS)  clocks elapsed in LISTEN (time-of-flight base).
- done_out  output  1  one-cycle pulse when LISTEN completes.
- fault_out  output  1  one-cycle pulse on arm timeout.

## Operation

- All outputs are registered.
- pwm_q is a one-flop copy of pwm_in. A rising edge ("edge") is pwm_in=1 && pwm_q=0.
- Latched length: len_q <= max(burst_len_in, 1). A value of 0 is clamped to 1. Values above MAX_BURST are clamped to MAX_BURST.

State machine (IDLE, ARM, BURST, LISTEN):
- IDLE:
  - trigger_in=1 && abort_in=0 -> ARM. Latch len_q. Clear arm_cnt.
- ARM:
  - Waits for an edge so the ping starts on a clean period.
  - On edge -> BURST, with edge_cnt<=1 and tx_out<=1.
  - Otherwise arm_cnt increments.
  - When arm_cnt reaches 2*PWM_PERIOD-1 -> IDLE and fault_out pulses.
- BURST:
  - tx_out <= pwm_in each cycle.
  - On an edge with edge_cnt==len_q -> LISTEN, with tx_out<=0 and listen_count<=0.
  - On an edge otherwise, edge_cnt increments.
  - Result: exactly len_q full periods, each a 1-clock-delayed copy of pwm_in.
- LISTEN:
  - listen_count increments every cycle.
  - On the cycle listen_count==LISTEN_CLOCKS-1 -> IDLE, done_out<=1 for one cycle, and listen_count<=0.
- abort_in=1 in ARM, BURST or LISTEN:
  - -> IDLE next cycle.
  - tx_out<=0 and counters cleared.
  - No done_out and no fault_out.
- Precedence: abort beats trigger in IDLE. Abort beats edge, timeout and listen completion in the same cycle.
- trigger_in while busy is ignored. No queuing.

## Timing

Reset values (asserted asynchronously):
- State IDLE.
- tx_out, busy_out, listen_out, done_out, fault_out all 0.
- listen_count_out, edge_cnt, arm_cnt, len_q, pwm_q all 0.
- rst_in mid-ping takes tx_out low immediately, without waiting for a clock edge.

Cycle-level behaviour:
- Trigger accepted at edge k: busy_out=1 from k+1.
- tx_out rises one clock after pwm_in rises on the first edge seen in ARM.
- tx_out falls one clock after pwm_in falls. Following periods track pwm_in the same way, delayed by one clock.
- Last period: tx_out low from the clock after the (len_q+1)-th edge. listen_out=1 from that same clock.
- listen_out is high for exactly LISTEN_CLOCKS cycles.
- done_out is coincident with the first IDLE cycle, when busy_out=0.
- A new trigger is accepted on the done_out cycle. Back-to-back pings have 0 dead cycles.
- Counter widths are sized to their maximum. Counters never wrap, because every terminal value forces a state exit.

## Test plan

Bench settings: PWM_PERIOD=10, pwm high 5/low 5, LISTEN_CLOCKS=50.

- Basic ping: trigger with burst_len_in=3.
  - Exactly 3 tx_out pulses, each 5 clocks high and 1 clock behind pwm_in.
  - listen_out high for 50 clocks.
  - listen_count_out ramps 0..49.
  - One done_out pulse.
- Zero length: burst_len_in=0.
  - Exactly 1 tx_out pulse.
- Over-range length: burst_len_in above MAX_BURST.
  - Exactly MAX_BURST pulses.
- Arm timeout: pwm_in held 0, then trigger.
  - fault_out pulses after 20 clocks in ARM.
  - Returns to IDLE. tx_out stays 0. No done_out.
- Abort mid-burst: abort_in asserted during the 2nd period of a 4-period ping.
  - tx_out 0 and busy_out 0 the next cycle. No done_out.
  - A trigger 1 cycle later starts a fresh ping.
- Async reset in LISTEN at listen_count=17:
  - All outputs zero before the next clock edge.
  - trigger_in held high through the done_out cycle of a normal ping: a second ping starts with zero gap.
